issue_stage: RTL and testbench



---
 rtl/issue_stage_pkg.sv | 33 +++
 rtl/issue_stage_if.sv | 13 +
 rtl/issue_scoreboard.sv | 45 ++++
 rtl/issue_stage.sv | 120 ++++++++++++
 tb/tb_issue_stage.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_stage_pkg.sv
// Shared types for the in-order issue stage: decoded instruction record,
// register index type and datapath width.
package issue_stage_pkg;

    localparam int XLEN    = 32;
    localparam int REG_CNT = 32;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [3:0] {
        OP_MISC = 4'd0,
        OP_LUI  = 4'd1,
        OP_ADD  = 4'd2,
        OP_ADDI = 4'd3,
        OP_SUB  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7
    } op_e;

    // rs1_val/rs2_val are don't-care on the decoder side; issue fills them in.
    typedef struct packed {
        op_e             op;
        reg_idx_t        rd;
        reg_idx_t        rs1;
        reg_idx_t        rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
    } decoded_instr;

endpackage

// File: rtl/issue_stage_if.sv
// Decoupled valid/ready channel carrying a decoded instruction record.
// master drives valid/data, slave drives ready.
interface issue_stage_if;
    import issue_stage_pkg::*;

    logic         valid;
    logic         ready;
    decoded_instr data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/issue_scoreboard.sv
// Pending-destination scoreboard: one busy bit per architectural register,
// set on issue, cleared on writeback, wiped on flush. x0 is never marked busy.
module issue_scoreboard
    import issue_stage_pkg::*;
#(
    parameter int REG_CNT = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  reg_idx_t q_rs1,
    input  reg_idx_t q_rs2,
    input  reg_idx_t q_rd,
    output logic     busy_rs1,
    output logic     busy_rs2,
    output logic     busy_rd
);

    logic [REG_CNT-1:0] busy;

    // Clear is applied before set so a same-index set/clear leaves the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (clr_en) begin
                busy[clr_idx] <= 1'b0;
            end
            if (set_en && (set_idx != '0)) begin
                busy[set_idx] <= 1'b1;
            end
        end
    end

    assign busy_rs1 = busy[q_rs1];
    assign busy_rs2 = busy[q_rs2];
    assign busy_rd  = busy[q_rd];

endmodule

// File: rtl/issue_stage.sv
// In-order issue stage: small instruction FIFO, scoreboard hazard check and
// register-file operand fetch. Define ISSUE_BYPASS_EN to forward writeback data.
module issue_stage #(
    parameter int DEPTH   = 2,
    parameter int XLEN    = 32,
    parameter int REG_CNT = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    issue_stage_if.slave              decoded,
    issue_stage_if.master             issued,
    output issue_stage_pkg::reg_idx_t rf_raddr1,
    input  logic [XLEN-1:0]           rf_rdata1,
    output issue_stage_pkg::reg_idx_t rf_raddr2,
    input  logic [XLEN-1:0]           rf_rdata2,
    input  logic                      wb_valid,
    input  issue_stage_pkg::reg_idx_t wb_idx,
    input  logic [XLEN-1:0]           wb_val,
    input  logic                      flush
);
    import issue_stage_pkg::*;

    localparam int              PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL  = (PTR_W + 1)'(DEPTH);

    decoded_instr     entries [DEPTH];
    decoded_instr     head_e;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic busy_rs1;
    logic busy_rs2;
    logic busy_rd;
    logic byp1;
    logic byp2;
    logic hazard;
    logic enq;
    logic fire;

    assign head_e        = entries[head];
    assign rf_raddr1     = head_e.rs1;
    assign rf_raddr2     = head_e.rs2;

    assign decoded.ready = (count != FULL);
    assign enq           = decoded.valid && decoded.ready && !flush;

`ifdef ISSUE_BYPASS_EN
    assign byp1 = wb_valid && (wb_idx == head_e.rs1) && (head_e.rs1 != '0);
    assign byp2 = wb_valid && (wb_idx == head_e.rs2) && (head_e.rs2 != '0);
`else
    logic unused_wb_val;
    assign byp1          = 1'b0;
    assign byp2          = 1'b0;
    assign unused_wb_val = ^wb_val;
`endif

    // WAW ignores the bypass: an older write to rd must retire first.
    assign hazard = (busy_rs1 && !byp1)
                 || (busy_rs2 && !byp2)
                 || (busy_rd && (head_e.rd != '0));

    assign issued.valid = (count != '0) && !hazard && !flush;
    assign fire         = issued.valid && issued.ready;

    always_comb begin
        issued.data         = head_e;
        issued.data.rs1_val = (head_e.rs1 == '0) ? '0 : (byp1 ? wb_val : rf_rdata1);
        issued.data.rs2_val = (head_e.rs2 == '0) ? '0 : (byp2 ? wb_val : rf_rdata2);
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            entries[tail] <= decoded.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (fire) begin
                head <= head + 1'b1;
            end
            case ({enq, fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    issue_scoreboard #(
        .REG_CNT (REG_CNT)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .set_en   (fire),
        .set_idx  (head_e.rd),
        .clr_en   (wb_valid),
        .clr_idx  (wb_idx),
        .q_rs1    (head_e.rs1),
        .q_rs2    (head_e.rs2),
        .q_rd     (head_e.rd),
        .busy_rs1 (busy_rs1),
        .busy_rs2 (busy_rs2),
        .busy_rd  (busy_rd)
    );

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: directed scenarios plus random traffic checked against
// a queue/busy-set reference model (honours ISSUE_BYPASS_EN when defined).
module tb_issue_stage;
    import issue_stage_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_stage_if decoded_bus ();
    issue_stage_if issued_bus ();

    reg_idx_t        rf_raddr1;
    reg_idx_t        rf_raddr2;
    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;
    logic            wb_valid;
    reg_idx_t        wb_idx;
    logic [XLEN-1:0] wb_val;
    logic            flush;

    logic [XLEN-1:0] rf [32];
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    issue_stage #(
        .DEPTH   (DEPTH),
        .XLEN    (XLEN),
        .REG_CNT (REG_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .decoded   (decoded_bus),
        .issued    (issued_bus),
        .rf_raddr1 (rf_raddr1),
        .rf_rdata1 (rf_rdata1),
        .rf_raddr2 (rf_raddr2),
        .rf_rdata2 (rf_rdata2),
        .wb_valid  (wb_valid),
        .wb_idx    (wb_idx),
        .wb_val    (wb_val),
        .flush     (flush)
    );

    int n_checks = 0;
    int n_pass   = 0;

    decoded_instr mq [$];
    bit           busy_m [32];
    logic         obs_valid;
    logic         obs_ready;
    decoded_instr obs_data;

    task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic decoded_instr mk(op_e op, int rd, int rs1, int rs2, logic [XLEN-1:0] pc);
        decoded_instr d;
        d         = '0;
        d.op      = op;
        d.rd      = reg_idx_t'(rd);
        d.rs1     = reg_idx_t'(rs1);
        d.rs2     = reg_idx_t'(rs2);
        d.imm     = pc ^ 32'h5a5a_0000;
        d.pc      = pc;
        d.rs1_val = $urandom;
        d.rs2_val = $urandom;
        return d;
    endfunction

    task automatic drive(input bit dv, input decoded_instr d, input bit rdy,
                         input bit wv, input int wi, input logic [XLEN-1:0] wd, input bit fl);
        decoded_bus.valid = dv;
        decoded_bus.data  = d;
        issued_bus.ready  = rdy;
        wb_valid          = wv;
        wb_idx            = reg_idx_t'(wi);
        wb_val            = wd;
        flush             = fl;
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, '0, rdy, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic model_reset();
        mq.delete();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        decoded_instr h;
        decoded_instr e;
        bit b1, b2, haz, exp_valid, exp_ready, fire;
        @(negedge clk);
        exp_ready = (mq.size() != DEPTH);
        exp_valid = 1'b0;
        e         = '0;
        if (mq.size() != 0) begin
            h  = mq[0];
            b1 = 1'b0;
            b2 = 1'b0;
`ifdef ISSUE_BYPASS_EN
            b1 = wb_valid && (wb_idx == h.rs1) && (h.rs1 != 0);
            b2 = wb_valid && (wb_idx == h.rs2) && (h.rs2 != 0);
`endif
            haz = (busy_m[h.rs1] && !b1) || (busy_m[h.rs2] && !b2)
               || ((h.rd != 0) && busy_m[h.rd]);
            exp_valid = !haz && !flush;
            e         = h;
            e.rs1_val = (h.rs1 == 0) ? '0 : (b1 ? wb_val : rf[h.rs1]);
            e.rs2_val = (h.rs2 == 0) ? '0 : (b2 ? wb_val : rf[h.rs2]);
        end
        obs_valid = issued_bus.valid;
        obs_ready = decoded_bus.ready;
        obs_data  = issued_bus.data;
        check_val("dec_ready", obs_ready, exp_ready);
        check_val("iss_valid", obs_valid, exp_valid);
        if (exp_valid) check_val("iss_data", obs_data, e);
        @(posedge clk);
        fire = exp_valid && issued_bus.ready;
        if (flush) begin
            model_reset();
        end else begin
            if (wb_valid) busy_m[wb_idx] = 1'b0;
            if (fire) begin
                if (mq[0].rd != 0) busy_m[mq[0].rd] = 1'b1;
                void'(mq.pop_front());
            end
            if (decoded_bus.valid && exp_ready) mq.push_back(decoded_bus.data);
        end
        if (wb_valid && (wb_idx != 0)) rf[wb_idx] = wb_val;
        #1;
    endtask

    initial begin
        foreach (rf[i]) rf[i] = $urandom;
        rf[0] = 32'hDEAD_BEEF;
        rf[1] = 32'h0000_0011;
        idle(1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_dec_ready", decoded_bus.ready, 1'b1);
        check_val("rst_iss_valid", issued_bus.valid, 1'b0);
        rst = 1'b0;

        // LUI x5 ; ADD x6, x5, x1 with x5 written back two cycles after LUI issues
        idle(1'b1); cycle();
        drive(1'b1, mk(OP_LUI, 5, 0, 0, 32'h100), 1'b1, 1'b0, 0, '0, 1'b0); cycle();
        drive(1'b1, mk(OP_ADD, 6, 5, 1, 32'h104), 1'b1, 1'b0, 0, '0, 1'b0); cycle();
        check_val("lui_issue", {obs_valid, obs_data.pc}, {1'b1, 32'h100});
        idle(1'b1); cycle();
        check_val("add_stall", obs_valid, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1, 5, 32'h1234, 1'b0); cycle();
`ifdef ISSUE_BYPASS_EN
        check_val("add_bypass_issue", {obs_valid, obs_data.pc}, {1'b1, 32'h104});
        check_val("add_bypass_rs1", obs_data.rs1_val, 32'h1234);
        idle(1'b1); cycle();
`else
        check_val("add_wb_cycle", obs_valid, 1'b0);
        idle(1'b1); cycle();
        check_val("add_issue", {obs_valid, obs_data.pc}, {1'b1, 32'h104});
        check_val("add_rs1", obs_data.rs1_val, 32'h1234);
        check_val("add_rs2", obs_data.rs2_val, 32'h11);
`endif

        // Fill with issue stalled, then drain while offering more
        drive(1'b0, '0, 1'b0, 1'b0, 0, '0, 1'b1); cycle();
        drive(1'b1, mk(OP_ADDI, 0, 0, 0, 32'h200), 1'b0, 1'b0, 0, '0, 1'b0); cycle();
        drive(1'b1, mk(OP_ADDI, 0, 0, 0, 32'h204), 1'b0, 1'b0, 0, '0, 1'b0); cycle();
        drive(1'b1, mk(OP_ADDI, 0, 0, 0, 32'h208), 1'b0, 1'b0, 0, '0, 1'b0); cycle();
        check_val("full_ready", obs_ready, 1'b0);
        drive(1'b1, mk(OP_ADDI, 0, 0, 0, 32'h208), 1'b1, 1'b0, 0, '0, 1'b0); cycle();
        check_val("full_no_pass", {obs_ready, obs_valid, obs_data.pc}, {1'b0, 1'b1, 32'h200});
        drive(1'b1, mk(OP_ADDI, 0, 0, 0, 32'h208), 1'b1, 1'b0, 0, '0, 1'b0); cycle();
        check_val("order_2", {obs_ready, obs_data.pc}, {1'b1, 32'h204});
        idle(1'b1); cycle();
        check_val("order_3", {obs_valid, obs_data.pc}, {1'b1, 32'h208});
        idle(1'b1); cycle();
        check_val("drained", obs_valid, 1'b0);

        // Flush with two buffered, busy[7] set and an enqueue in the same cycle
        drive(1'b1, mk(OP_LUI, 7, 0, 0, 32'h300), 1'b1, 1'b0, 0, '0, 1'b0); cycle();
        drive(1'b1, mk(OP_ADDI, 1, 0, 0, 32'h304), 1'b1, 1'b0, 0, '0, 1'b0); cycle();
        drive(1'b1, mk(OP_ADDI, 2, 0, 0, 32'h308), 1'b0, 1'b0, 0, '0, 1'b0); cycle();
        drive(1'b1, mk(OP_ADDI, 3, 0, 0, 32'h30c), 1'b1, 1'b0, 0, '0, 1'b1); cycle();
        check_val("flush_valid", obs_valid, 1'b0);
        idle(1'b1); cycle();
        check_val("post_flush", {obs_ready, obs_valid}, {1'b1, 1'b0});
        drive(1'b1, mk(OP_ADD, 8, 7, 7, 32'h310), 1'b1, 1'b0, 0, '0, 1'b0); cycle();
        idle(1'b1); cycle();
        check_val("busy7_cleared", {obs_valid, obs_data.pc}, {1'b1, 32'h310});

        // rd = x0 sets nothing; a reader of x0 sees zero
        drive(1'b1, mk(OP_ADDI, 0, 0, 0, 32'h400), 1'b1, 1'b0, 0, '0, 1'b0); cycle();
        drive(1'b1, mk(OP_ADD, 10, 0, 0, 32'h404), 1'b1, 1'b0, 0, '0, 1'b0); cycle();
        check_val("x0_dest_issue", {obs_valid, obs_data.pc}, {1'b1, 32'h400});
        idle(1'b1); cycle();
        check_val("x0_src_issue", {obs_valid, obs_data.pc}, {1'b1, 32'h404});
        check_val("x0_src_val", obs_data.rs1_val, 32'h0);

        // Issue rd = x9 in the same cycle as a writeback to x9: busy wins
        drive(1'b1, mk(OP_LUI, 9, 0, 0, 32'h500), 1'b1, 1'b0, 0, '0, 1'b0); cycle();
        drive(1'b1, mk(OP_ADD, 11, 9, 0, 32'h504), 1'b1, 1'b1, 9, 32'h99, 1'b0); cycle();
        check_val("rd9_issue", {obs_valid, obs_data.pc}, {1'b1, 32'h500});
        idle(1'b1); cycle();
        check_val("rd9_still_busy", obs_valid, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1, 9, 32'h77, 1'b0); cycle();
        idle(1'b1); cycle();

        // Asynchronous reset between clock edges
        drive(1'b0, '0, 1'b0, 1'b0, 0, '0, 1'b1); cycle();
        drive(1'b1, mk(OP_ADDI, 3, 0, 0, 32'h600), 1'b0, 1'b0, 0, '0, 1'b0); cycle();
        idle(1'b0);
        #2;
        check_val("pre_rst_valid", issued_bus.valid, 1'b1);
        rst = 1'b1;
        #1;
        check_val("async_rst_valid", issued_bus.valid, 1'b0);
        check_val("async_rst_ready", decoded_bus.ready, 1'b1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int n = 0; n < 1500; n++) begin
            decoded_instr d;
            d = mk(op_e'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), $urandom);
            drive($urandom_range(0, 9) < 6, d, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 3, int'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 49) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
